fifo_wptr_full: RTL and testbench

// Write-side pointer and full-flag generator for the asynchronous CDC FIFO.
// - Runs entirely in the write clock domain.
// - Directly upstream of the FIFO memory: drives its write address (waddr) and write enable (wclken).
// - Exports a Gray-coded write pointer for the read-domain synchronizer.
// - Takes in a read pointer that has already been double-synchronized into this domain.

---
 rtl/fifo_wptr_full_if.sv | 33 +++
 rtl/fifo_wptr_full.sv | 91 +++++++++
 tb/tb_fifo_wptr_full.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO pointer block: producer requests,
// synchronized read pointer in, memory controls and status flags out.
//
// Handshake: a write is taken on a rising clk edge when winc=1 and the
// registered wfull=0. wclken is the combinational acknowledge for the memory
// in that same cycle. With winc=1 and wfull=1 the write is dropped and wovf
// is set. There is no back-pressure beyond wfull.
interface fifo_wptr_full_if #(
  parameter int ASIZE = 7
) ();
  logic             winc;
  logic [ASIZE:0]   wq2_rptr;
  logic             wovf_clr;
  logic [ASIZE-1:0] waddr;
  logic             wclken;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             walmost_full;
  logic [ASIZE:0]   wlevel;
  logic             wovf;

  // Producer side: drives requests and the synchronized read pointer.
  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wclken, wptr, wfull, walmost_full, wlevel, wovf
  );

  // Pointer block side.
  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wclken, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag generator for the async CDC FIFO.
// Keeps a binary write pointer with a wrap bit and exports its Gray form to
// the read domain. It registers full, almost-full and occupancy, computed
// against a read pointer that is already synchronized into this domain.
module fifo_wptr_full #(
  parameter int ASIZE     = 7,
  parameter int AF_THRESH = 120
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wptr_full_if.slave    bus
);

  localparam int PW = ASIZE + 1;
  localparam logic [ASIZE:0] AF_LVL = PW'(AF_THRESH);

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbinnext;
  logic [ASIZE:0] wgraynext;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rptr_full_cmp;
  logic [ASIZE:0] lvl_next;
  logic           wclken;
  logic           full_next;
  logic           af_next;
  logic           ovf_next;

  // Accept a write only when not full. While reset is held, nothing is
  // accepted, even though the flags are already clear.
  assign wclken = bus.winc & ~bus.wfull & rst;

  // Next binary/Gray pointer. The wrap bit overflows naturally.
  always_comb begin
    wbinnext  = wbin + PW'(wclken);
    wgraynext = (wbinnext >> 1) ^ wbinnext;
  end

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of
  // all Gray bits from i up to the MSB.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Full when the next write pointer equals the read pointer with the two
  // Gray MSBs inverted, i.e. exactly one lap ahead.
  always_comb begin
    rptr_full_cmp = {~bus.wq2_rptr[ASIZE:ASIZE-1], bus.wq2_rptr[ASIZE-2:0]};
    full_next     = (wgraynext == rptr_full_cmp);
    lvl_next      = wbinnext - rbin;
    af_next       = (lvl_next >= AF_LVL);
  end

  // Sticky overflow: a dropped write sets it, and setting wins over clearing.
  always_comb begin
    ovf_next = bus.wovf;
    if (bus.winc && bus.wfull && rst) begin
      ovf_next = 1'b1;
    end else if (bus.wovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  // Pointer and flag registers, all cleared to "empty" by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin             <= '0;
      bus.wptr         <= '0;
      bus.wfull        <= 1'b0;
      bus.walmost_full <= 1'b0;
      bus.wlevel       <= '0;
      bus.wovf         <= 1'b0;
    end else begin
      wbin             <= wbinnext;
      bus.wptr         <= wgraynext;
      bus.wfull        <= full_next;
      bus.walmost_full <= af_next;
      bus.wlevel       <= lvl_next;
      bus.wovf         <= ovf_next;
    end
  end

  // Memory-side outputs. The write lands at the pre-increment address.
  always_comb begin
    bus.waddr  = wbin[ASIZE-1:0];
    bus.wclken = wclken;
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (ASIZE=7, AF_THRESH=120).
// The reference model tracks total writes/reads as plain integers; occupancy
// is their difference, and full means occupancy equals the depth.
module tb_fifo_wptr_full;

  localparam int ASIZE = 7;
  localparam int DEPTH = 128;
  localparam int AFTH  = 120;

  logic clk;
  logic rst;

  fifo_wptr_full_if #(.ASIZE(ASIZE)) bus ();

  fifo_wptr_full #(.ASIZE(ASIZE), .AF_THRESH(AFTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int   m_w     = 0;   // accepted writes since reset
  int   m_r     = 0;   // reads visible through wq2_rptr
  int   m_level = 0;
  logic m_full  = 1'b0;
  logic m_af    = 1'b0;
  logic m_ovf   = 1'b0;

  // scoreboard of accepted write addresses, consumed when the pointer moves
  logic [ASIZE-1:0] exp_q[$];

  typedef struct {
    logic       winc;
    logic [7:0] rq;
    logic       clr;
    logic       exp_wclken;
    logic [6:0] exp_waddr;
    logic [7:0] exp_wptr;
    logic [7:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t tv[6];

  function automatic logic [7:0] to_gray(input int v);
    logic [7:0] b;
    b = 8'(v % 256);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_waddr"},  32'(bus.waddr), 0);
    check({tag, "_wclken"}, 32'(bus.wclken), 0);
    check({tag, "_wptr"},   32'(bus.wptr), 0);
    check({tag, "_wfull"},  32'(bus.wfull), 0);
    check({tag, "_walmost"},32'(bus.walmost_full), 0);
    check({tag, "_wlevel"}, 32'(bus.wlevel), 0);
    check({tag, "_wovf"},   32'(bus.wovf), 0);
  endtask

  // Hold reset with winc high, check cleared outputs, release between edges.
  task automatic do_reset();
    bus.winc = 1'b1; bus.wq2_rptr = '0; bus.wovf_clr = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    bus.winc = 1'b0;
    rst = 1'b1;
  endtask

  // driver task: one clock cycle of stimulus checked against the model
  task automatic step(input logic wi, input int rt, input logic clr);
    logic [7:0] prev_wptr;
    logic       acc;
    logic       set;
    bus.winc = wi; bus.wq2_rptr = to_gray(rt); bus.wovf_clr = clr;
    #1;
    check("wclken", 32'(bus.wclken), 32'(wi && !m_full));
    check("waddr_pre", 32'(bus.waddr), 32'(m_w % DEPTH));
    prev_wptr = bus.wptr;
    @(posedge clk);
    acc = wi && !m_full;
    set = wi && m_full;
    if (acc) exp_q.push_back(7'(m_w % DEPTH));
    m_w += int'(acc);
    m_r = rt;
    m_level = m_w - m_r;
    m_full = (m_level == DEPTH);
    m_af = (m_level >= AFTH);
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    if (acc) begin
      // the address just written is one behind the new waddr
      check("write_addr", 32'(7'(bus.waddr - 7'd1)), 32'(exp_q.pop_front()));
    end
    check("waddr", 32'(bus.waddr), 32'(m_w % DEPTH));
    check("wptr", 32'(bus.wptr), 32'(to_gray(m_w)));
    check("wfull", 32'(bus.wfull), 32'(m_full));
    check("walmost_full", 32'(bus.walmost_full), 32'(m_af));
    check("wlevel", 32'(bus.wlevel), 32'(m_level));
    check("wovf", 32'(bus.wovf), 32'(m_ovf));
    check("wptr_onebit", 32'($countones(bus.wptr ^ prev_wptr) <= 1), 1);
  endtask

  initial begin
    int   nr;
    int   pw;
    logic saw_wrap;
    logic [7:0] pwp;

    tv[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 7'd1, 8'h01, 8'd1, 1'b0, 1'b0};
    tv[1] = '{1'b1, 8'h00, 1'b0, 1'b1, 7'd2, 8'h03, 8'd2, 1'b0, 1'b0};
    tv[2] = '{1'b0, 8'h01, 1'b0, 1'b0, 7'd2, 8'h03, 8'd1, 1'b0, 1'b0};
    tv[3] = '{1'b1, 8'h01, 1'b0, 1'b1, 7'd3, 8'h02, 8'd2, 1'b0, 1'b0};
    tv[4] = '{1'b0, 8'h02, 1'b0, 1'b0, 7'd3, 8'h02, 8'd0, 1'b0, 1'b0};
    tv[5] = '{1'b1, 8'h02, 1'b1, 1'b1, 7'd4, 8'h06, 8'd1, 1'b0, 1'b0};

    rst = 1'b0;
    bus.winc = 1'b0; bus.wq2_rptr = '0; bus.wovf_clr = 1'b0;

    // 1. reset with winc held high
    do_reset();

    // table-driven vectors from empty
    for (int i = 0; i < 6; i++) begin
      bus.winc = tv[i].winc; bus.wq2_rptr = tv[i].rq; bus.wovf_clr = tv[i].clr;
      #1;
      check("tv_wclken", 32'(bus.wclken), 32'(tv[i].exp_wclken));
      @(posedge clk);
      #1;
      check("tv_waddr", 32'(bus.waddr), 32'(tv[i].exp_waddr));
      check("tv_wptr", 32'(bus.wptr), 32'(tv[i].exp_wptr));
      check("tv_wlevel", 32'(bus.wlevel), 32'(tv[i].exp_level));
      check("tv_wfull", 32'(bus.wfull), 32'(tv[i].exp_full));
      check("tv_wovf", 32'(bus.wovf), 32'(tv[i].exp_ovf));
    end

    // 2. fill from empty
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 0, 1'b0);
      if (i == AFTH - 2) check("fill_af_before", 32'(bus.walmost_full), 0);
      if (i == AFTH - 1) check("fill_af_at", 32'(bus.walmost_full), 1);
      if (i == DEPTH - 2) check("fill_not_full_early", 32'(bus.wfull), 0);
    end
    check("fill_wfull", 32'(bus.wfull), 1);
    check("fill_wlevel", 32'(bus.wlevel), 128);
    check("fill_wptr", 32'(bus.wptr), 32'h0c0);
    check("fill_waddr", 32'(bus.waddr), 0);

    // 3. overflow, clear, then set-wins-over-clear
    step(1'b1, 0, 1'b0);
    check("ovf_set", 32'(bus.wovf), 1);
    check("ovf_waddr_hold", 32'(bus.waddr), 0);
    step(1'b0, 0, 1'b1);
    check("ovf_clr", 32'(bus.wovf), 0);
    step(1'b1, 0, 1'b1);
    check("ovf_set_wins", 32'(bus.wovf), 1);
    step(1'b0, 0, 1'b1);

    // 4. drain one entry, then refill
    step(1'b0, 1, 1'b0);
    check("drain_wfull", 32'(bus.wfull), 0);
    check("drain_wlevel", 32'(bus.wlevel), 127);
    step(1'b1, 1, 1'b0);
    check("refill_wfull", 32'(bus.wfull), 1);

    // 5. steady traffic across the pointer wrap
    saw_wrap = 1'b0;
    for (int i = 0; i < 400; i++) begin
      nr = (m_w - 3 > m_r) ? m_w - 3 : m_r;
      pwp = bus.wptr;
      step(1'b1, nr, 1'b0);
      if (pwp == 8'h80 && bus.wptr == 8'h00) saw_wrap = 1'b1;
    end
    check("wrap_80_to_00", 32'(saw_wrap), 1);

    // randomized traffic: write-heavy, balanced, read-heavy phases
    for (int i = 0; i < 2000; i++) begin
      pw = (i < 700) ? 90 : ((i < 1400) ? 50 : 15);
      nr = m_r + $urandom_range(0, (i < 700) ? 1 : 3);
      if (nr > m_w) nr = m_w;
      step(($urandom_range(0, 99) < pw), nr, ($urandom_range(0, 7) == 0));
    end

    // 6. async reset mid-fill at level 50
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 0, 1'b0);
    check("midfill_level", 32'(bus.wlevel), 50);
    bus.winc = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    bus.winc = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
